sum_extend_stage: RTL
=====================

SUM_EXTEND_STAGE -- requirements
Module: sum_extend_stage

Interface
REQ-001 Parameter AW, default 15: width of operand A.
REQ-002 Parameter BW, default 16: width of operand B; BW >= AW.
REQ-003 Parameter ACC_W, default 24: accumulator width; ACC_W >= BW+1.
REQ-004 Derived constant SW = BW+1: full-sum width.
REQ-005 Port clk_i, input, 1: sole clock, rising edge.
REQ-006 Port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 Port in_valid_i, input, 1: operand beat offered.
REQ-008 Port in_ready_o, output, 1: stage accepts a beat this cycle.
REQ-009 Port a_i, input, AW: operand A.
REQ-010 Port b_i, input, BW: operand B.
REQ-011 Port signed_i, input, 1: 1 = sign-extend operands and accumulator; 0 = zero-extend; sampled with the beat.
REQ-012 Port acc_en_i, input, 1: add this beat's sum into the accumulator; sampled with the beat.
REQ-013 Port acc_clr_i, input, 1: clear the accumulator.
REQ-014 Port out_valid_o, output, 1: result beat available.
REQ-015 Port out_ready_i, input, 1: downstream consumes the beat.
REQ-016 Port sum_full_o, output, SW: context-widened sum.
REQ-017 Port sum_trunc_o, output, BW: sum truncated to BW.
REQ-018 Port ovf_o, output, 1: truncation changed the value.
REQ-019 Port acc_o, output, ACC_W: accumulator value after this beat.
REQ-020 Port acc_sat_o, output, 1: accumulator saturated on this beat.

Function
REQ-021 Accept = in_valid_i & in_ready_o at a rising edge; consume = out_valid_o & out_ready_i.
REQ-022 Results are held in a 2-entry in-order result buffer; in_ready_o = (count < 2) & ~rst_i.
REQ-023 Latency: a beat accepted at edge N appears at the buffer output in the cycle after edge N when the buffer was empty or popped at edge N.
REQ-024 Simultaneous accept and consume leave count unchanged; order is preserved; count never exceeds 2 or underflows.
REQ-025 Outputs present the head entry; they hold stable while out_valid_o=1 and out_ready_i=0.
REQ-026 Both operands are extended to SW bits, sign-extended when signed_i=1, else zero-extended; sum_full = extA + extB modulo 2^SW.
REQ-027 sum_trunc_o = sum_full[BW-1:0].
REQ-028 ovf_o = 1 iff extending sum_trunc_o back to SW bits (same signedness) differs from sum_full.
REQ-029 On an accept with acc_en_i=1: acc_next = sat(acc_base + ext_ACC_W(sum_full)), with signedness per signed_i.
REQ-030 acc_base = 0 if acc_clr_i=1, else the current accumulator.
REQ-031 Unsigned saturation to 2^ACC_W-1; signed saturation to max/min two's complement.
REQ-032 acc_sat_o = 1 iff clamping occurred.
REQ-033 On an accept with acc_en_i=0: the accumulator is unchanged (cleared if acc_clr_i=1), acc_sat_o=0, and acc_o carries the resulting value.
REQ-034 acc_clr_i=1 without an accept clears the accumulator at that edge.
REQ-035 Accumulator updates at accept time, not consume time; the buffered acc_o is a snapshot.

Reset
REQ-036 While rst_i=1 at an edge: buffer count := 0, accumulator := 0, all entries := 0.
REQ-037 Reset values: out_valid_o=0, sum_full_o=0, sum_trunc_o=0, ovf_o=0, acc_o=0, acc_sat_o=0, in_ready_o=0 during reset and 1 in the first cycle after.
REQ-038 Reset mid-operation discards buffered beats; no beat is accepted in a reset cycle.

Verification
REQ-039 Unsigned: a=0x7FFF, b=0xFFFF, signed_i=0 -> sum_full=0x17FFE, sum_trunc=0x7FFE, ovf=1, one cycle after accept.
REQ-040 Signed: a=0x7FFF (-1), b=0xFFFF (-1), signed_i=1 -> sum_full=0x1FFFE, sum_trunc=0xFFFE, ovf=0; a=0x3FFF, b=0x7FFF -> sum_full=0x0BFFE, ovf=1.
REQ-041 Backpressure: out_ready_i=0, offer 3 beats back-to-back -> 2 accepted, in_ready_o=0 from the 3rd cycle. Raise out_ready_i -> beats emerge in order with no loss or duplication.
REQ-042 Saturation: ACC_W=18, unsigned, acc_en_i=1, acc_clr_i on the first beat, three beats summing 0x17FFE -> acc_o=0x17FFE, 0x2FFFC, 0x3FFFF with acc_sat_o=0,0,1. Signed negative clamp reaches 0x20000.
REQ-043 Streaming: out_ready_i=1, 16 consecutive beats -> one result per cycle, in_ready_o stays 1.
REQ-044 Reset with 2 buffered beats -> out_valid_o=0 and acc_o=0 the next cycle; a fresh beat then completes normally.

Source files
------------

// File: rtl/sum_extend_stage.sv
// sum_extend_stage
//   Adds operand A (AW bits) to operand B (BW bits) after signed or unsigned
//   extension to SW = BW+1 bits. It reports the full sum, the sum truncated
//   to BW bits, and a flag set when truncation changed the value. Each beat
//   may also add its full sum into a saturating ACC_W-bit accumulator.
//   Results queue in a 2-entry in-order buffer with valid/ready on both sides.
//
// Ports
//   clk_i, rst_i            : clock (rising edge), synchronous active-high reset
//   in_valid_i / in_ready_o : input handshake; a beat is accepted when both are 1
//   a_i, b_i                : operands
//   signed_i                : 1 = sign-extend operands and accumulator, 0 = zero-extend
//   acc_en_i                : add this beat's full sum into the accumulator
//   acc_clr_i               : clear the accumulator; with a beat, the beat starts from 0
//   out_valid_o/out_ready_i : output handshake; a result is consumed when both are 1
//   sum_full_o              : SW-bit sum
//   sum_trunc_o             : sum_full_o[BW-1:0]
//   ovf_o                   : truncated sum re-extended differs from the full sum
//   acc_o                   : accumulator value after this beat (snapshot)
//   acc_sat_o               : accumulator clamped on this beat
module sum_extend_stage #(
    parameter int AW    = 15,
    parameter int BW    = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [AW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    input  logic             signed_i,
    input  logic             acc_en_i,
    input  logic             acc_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BW:0]      sum_full_o,
    output logic [BW-1:0]    sum_trunc_o,
    output logic             ovf_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             acc_sat_o
);

    localparam int SW = BW + 1;

    function automatic logic [SW-1:0] ext_a(input logic [AW-1:0] v, input logic sgn);
        return {{(SW-AW){sgn & v[AW-1]}}, v};
    endfunction

    function automatic logic [SW-1:0] ext_b(input logic [BW-1:0] v, input logic sgn);
        return {sgn & v[BW-1], v};
    endfunction

    // SW is exactly BW+1, so re-extending the truncated sum only changes the
    // value when the top bit disagrees with the extension of bit BW-1.
    function automatic logic trunc_ovf(input logic [SW-1:0] s, input logic sgn);
        return s[SW-1] != (sgn & s[SW-2]);
    endfunction

    // Returns {sat, value}. The base and addend are widened by one bit so the
    // carry/sign of the true result is visible before clamping.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base,
                                               input logic [SW-1:0]    s,
                                               input logic             sgn);
        logic [ACC_W:0]   wide_base;
        logic [ACC_W:0]   wide_sum;
        logic [ACC_W:0]   total;
        logic [ACC_W-1:0] val;
        logic             sat;
        wide_base = {sgn & base[ACC_W-1], base};
        wide_sum  = {{(ACC_W+1-SW){sgn & s[SW-1]}}, s};
        total     = wide_base + wide_sum;
        if (!sgn) begin
            sat = total[ACC_W];
            val = sat ? '1 : total[ACC_W-1:0];
        end else begin
            sat = total[ACC_W] ^ total[ACC_W-1];
            if (!sat)
                val = total[ACC_W-1:0];
            else if (total[ACC_W])
                val = {1'b1, {(ACC_W-1){1'b0}}};
            else
                val = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return {sat, val};
    endfunction

    // ---- stage p0: combinational sum and accumulator update for the offered beat
    logic [SW-1:0]    sum_full_p0;
    logic [BW-1:0]    sum_trunc_p0;
    logic             ovf_p0;
    logic [ACC_W-1:0] acc_base_p0;
    logic [ACC_W:0]   acc_res_p0;

    logic [ACC_W-1:0] acc_q;
    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             accept;
    logic             consume;

    assign sum_full_p0  = ext_a(a_i, signed_i) + ext_b(b_i, signed_i);
    assign sum_trunc_p0 = sum_full_p0[BW-1:0];
    assign ovf_p0       = trunc_ovf(sum_full_p0, signed_i);
    assign acc_base_p0  = acc_clr_i ? '0 : acc_q;
    assign acc_res_p0   = acc_en_i ? sat_add(acc_base_p0, sum_full_p0, signed_i)
                                   : {1'b0, acc_base_p0};

    assign in_ready_o  = (count < 2'd2) & ~rst_i;
    assign out_valid_o = (count != 2'd0);
    assign accept      = in_valid_i & in_ready_o;
    assign consume     = out_valid_o & out_ready_i;

    // ---- stage p1: 2-entry result buffer
    logic [SW-1:0]    full_p1  [2];
    logic [BW-1:0]    trunc_p1 [2];
    logic             ovf_p1   [2];
    logic [ACC_W-1:0] acc_p1   [2];
    logic             sat_p1   [2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            acc_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                full_p1[i]  <= '0;
                trunc_p1[i] <= '0;
                ovf_p1[i]   <= 1'b0;
                acc_p1[i]   <= '0;
                sat_p1[i]   <= 1'b0;
            end
        end else begin
            if (accept) begin
                full_p1[wr_ptr]  <= sum_full_p0;
                trunc_p1[wr_ptr] <= sum_trunc_p0;
                ovf_p1[wr_ptr]   <= ovf_p0;
                acc_p1[wr_ptr]   <= acc_res_p0[ACC_W-1:0];
                sat_p1[wr_ptr]   <= acc_res_p0[ACC_W];
                wr_ptr           <= ~wr_ptr;
                acc_q            <= acc_res_p0[ACC_W-1:0];
            end else if (acc_clr_i) begin
                acc_q <= '0;
            end
            if (consume)
                rd_ptr <= ~rd_ptr;
            case ({accept, consume})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign sum_full_o  = full_p1[rd_ptr];
    assign sum_trunc_o = trunc_p1[rd_ptr];
    assign ovf_o       = ovf_p1[rd_ptr];
    assign acc_o       = acc_p1[rd_ptr];
    assign acc_sat_o   = sat_p1[rd_ptr];

endmodule
